// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared definitions for the byte-wide UART receiver: the
//                receiver state enumeration and the baud divisor helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Receiver states. WAIT_HIGH parks the receiver after a framing error
    // until the line returns high, so a held-low line (break) is reported
    // only once.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Clock cycles per serial bit (integer division).
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous input bit.
//  Ports       : clk - clock
//                rst - synchronous active-high reset (both flops -> RESET_VAL)
//                d   - asynchronous input
//                q   - synchronized output (2 cycles latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART receiver. Samples the synchronized line at the
//                middle of each bit, holds the last well-framed byte.
//  Ports       : clk        - clock, CLK_HZ Hz
//                rst        - synchronous active-high reset
//                rxd        - asynchronous serial input, idle high, LSB first
//                byte_out   - last correctly framed byte
//                byte_valid - one-cycle pulse when byte_out updates
//                frame_err  - one-cycle pulse when the stop bit samples low
//                busy       - high whenever the receiver is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned c_DIV  = calc_div(CLK_HZ, BAUD);
    localparam int unsigned c_HALF = c_DIV / 2;
    localparam int          c_TW   = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    localparam logic [c_TW-1:0] c_DIV_END  = c_TW'(c_DIV - 1);
    localparam logic [c_TW-1:0] c_HALF_END = c_TW'(c_HALF - 1);

    // Fewer than 4 clocks per bit leaves no usable mid-bit sample point.
    if (c_DIV < 4) begin : g_div_check
        $fatal(1, "uart_rx_byte: CLK_HZ/BAUD must be at least 4");
    end

    logic            w_rxs;
    rx_state_t       r_state,    w_state_nxt;
    logic [c_TW-1:0] r_timer,    w_timer_nxt;
    logic [2:0]      r_bitcnt,   w_bitcnt_nxt;
    logic [7:0]      r_shift,    w_shift_nxt;
    logic [7:0]      r_byte,     w_byte_nxt;
    logic            r_valid,    w_valid_nxt;
    logic            r_err,      w_err_nxt;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_byte   <= w_byte_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer + c_TW'(1);
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_byte_nxt   = r_byte;
        w_valid_nxt  = 1'b0;
        w_err_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = START;
                end
            end

            // Re-check the start bit half a bit later to reject glitches;
            // the DATA timer then runs from the start-bit centre.
            START: begin
                if (r_timer == c_HALF_END) begin
                    w_timer_nxt = '0;
                    w_state_nxt = w_rxs ? IDLE : DATA;
                end
            end

            DATA: begin
                if (r_timer == c_DIV_END) begin
                    w_timer_nxt  = '0;
                    w_shift_nxt  = {w_rxs, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;   // 7 wraps to 0 entering STOP
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end

            // Returning straight to IDLE at the stop-bit centre leaves half a
            // bit to catch a back-to-back start edge.
            STOP: begin
                if (r_timer == c_DIV_END) begin
                    w_timer_nxt = '0;
                    if (w_rxs) begin
                        w_byte_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                w_timer_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_timer_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign byte_out   = r_byte;
    assign byte_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_byte
//  Description : Scoreboard bench for uart_rx_byte at DIV = 10. Stimulus
//                pushes expected events; a monitor pops them on each
//                byte_valid / frame_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int c_PER     = 10;   // clock period, time units
    localparam int c_BIT     = 10;   // clocks per serial bit
    localparam int c_LATENCY = 98;   // start edge to pulse, sampled on negedge

    typedef struct {
        bit         is_err;
        logic [7:0] data;    // expected byte_out while the pulse is high
        longint     t0;      // time of the start edge
    } exp_t;

    logic       clk;
    logic       rst;
    logic       r_rxd;
    logic [7:0] w_byte_out;
    logic       w_byte_valid;
    logic       w_frame_err;
    logic       w_busy;

    exp_t       r_q[$];
    int         n_vec;
    int         n_err;
    logic [7:0] r_last_good;

    uart_rx_byte #(
        .CLK_HZ (1_000_000),
        .BAUD   (100_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (r_rxd),
        .byte_out   (w_byte_out),
        .byte_valid (w_byte_valid),
        .frame_err  (w_frame_err),
        .busy       (w_busy)
    );

    initial clk = 1'b0;
    always #(c_PER / 2) clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Caller is positioned at a negedge; returns n negedges later.
    task automatic drive(input logic v, input int n);
        r_rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int stop_len, input bit expect_evt);
        exp_t e;
        e.is_err = !stop_val;
        e.data   = stop_val ? b : r_last_good;
        e.t0     = longint'($time);
        if (expect_evt) r_q.push_back(e);
        drive(1'b0, c_BIT);
        for (int i = 0; i < 8; i++) drive(b[i], c_BIT);
        drive(stop_val, stop_len);
        if (stop_val) r_last_good = b;
    endtask

    // Monitor: every output pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (w_byte_valid || w_frame_err)) begin
            exp_t e;
            chk("valid_err_exclusive", {63'd0, w_byte_valid & w_frame_err}, 64'd0);
            if (r_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b, expected none",
                         w_byte_valid, w_frame_err);
            end else begin
                e = r_q.pop_front();
                chk("pulse_kind_err", {63'd0, w_frame_err}, {63'd0, e.is_err});
                chk("byte_out", {56'd0, w_byte_out}, {56'd0, e.data});
                chk("latency", 64'((longint'($time) - e.t0) / c_PER), 64'(c_LATENCY));
            end
        end
    end

    initial begin
        #(c_PER * 20000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        r_last_good = 8'h00;
        r_rxd       = 1'b1;
        rst         = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_byte_out", {56'd0, w_byte_out}, 64'h00);
        chk("rst_valid",    {63'd0, w_byte_valid}, 64'd0);
        chk("rst_err",      {63'd0, w_frame_err}, 64'd0);
        chk("rst_busy",     {63'd0, w_busy}, 64'd0);
        rst = 1'b0;
        drive(1'b1, 5);

        // Good frame
        send_frame(8'hA5, 1'b1, c_BIT, 1'b1);
        drive(1'b1, 10);

        // Start-bit glitch
        drive(1'b0, 3);
        drive(1'b1, 20);
        chk("glitch_busy",     {63'd0, w_busy}, 64'd0);
        chk("glitch_byte_out", {56'd0, w_byte_out}, 64'hA5);

        // Framing error with line held low (break)
        send_frame(8'h3C, 1'b0, 40, 1'b1);
        chk("break_busy",     {63'd0, w_busy}, 64'd1);
        chk("break_byte_out", {56'd0, w_byte_out}, 64'hA5);
        drive(1'b1, 10);
        chk("break_release_busy", {63'd0, w_busy}, 64'd0);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, c_BIT, 1'b1);
        send_frame(8'hFF, 1'b1, c_BIT, 1'b1);
        drive(1'b1, 10);
        chk("b2b_byte_out", {56'd0, w_byte_out}, 64'hFF);

        // Reset during the 4th data bit of 0x96 (bit3 = 0)
        drive(1'b0, c_BIT);
        drive(1'b0, c_BIT);
        drive(1'b1, c_BIT);
        drive(1'b1, c_BIT);
        drive(1'b0, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_byte_out", {56'd0, w_byte_out}, 64'h00);
        chk("midrst_busy",     {63'd0, w_busy}, 64'd0);
        rst         = 1'b0;
        r_last_good = 8'h00;
        drive(1'b1, 20);
        chk("post_rst_idle", {63'd0, w_busy}, 64'd0);

        send_frame(8'h5A, 1'b1, c_BIT, 1'b1);
        drive(1'b1, 20);
        chk("final_byte_out", {56'd0, w_byte_out}, 64'h5A);

        // Drain, bounded
        for (int i = 0; i < 200 && r_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 64'(r_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_byte.md
UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, SHALL give the clk frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, SHALL give the serial bit rate.
REQ-003 Port clk, input, 1, SHALL be the single rising-edge clock.
REQ-004 Port rst, input, 1, SHALL be the reset, synchronous and active-high.
REQ-005 Port rxd, input, 1, SHALL be the asynchronous serial line, 8N1, idle high, LSB first.
REQ-006 Port byte_out, output, 8, SHALL hold the last correctly framed byte and drive the display value input of the downstream seven-segment stage.
REQ-007 Port byte_valid, output, 1, SHALL pulse high for one cycle when byte_out is updated.
REQ-008 Port frame_err, output, 1, SHALL pulse high for one cycle when a stop bit samples low.
REQ-009 Port busy, output, 1, SHALL be high in every state except IDLE.

Function
REQ-010 DIV = CLK_HZ/BAUD (integer) and HALF = DIV/2 SHALL be derived at elaboration, and DIV < 4 SHALL abort elaboration.
REQ-011 rxd SHALL pass through a 2-flop synchronizer, and all decisions SHALL use the synchronized value rxs, giving 2 cycles of input latency.
REQ-012 The FSM SHALL have exactly five states: IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 In IDLE, rxs = 0 SHALL move the FSM to START and clear the bit timer.
REQ-014 In START, at timer = HALF-1, rxs = 1 SHALL return the FSM to IDLE as a glitch, and rxs = 0 SHALL move it to DATA with the timer cleared.
REQ-015 In DATA, at each timer = DIV-1, rxs SHALL be shifted into the shift register MSB-side (LSB first on the line) and the timer cleared; after the 8th bit the FSM SHALL enter STOP.
REQ-016 In STOP, at timer = DIV-1, rxs = 1 SHALL move shift to byte_out, pulse byte_valid the following cycle and enter IDLE.
REQ-017 In STOP, at timer = DIV-1, rxs = 0 SHALL leave byte_out unchanged, pulse frame_err the following cycle and enter WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL enter IDLE on the first cycle with rxs = 1, so that a break condition never produces repeated frames.
REQ-019 A start bit beginning immediately after the stop-bit sample point (no idle gap) SHALL be received without loss.
REQ-020 The bit timer SHALL be ceil(log2(DIV)) bits wide, and the bit counter SHALL be 3 bits wide, wrapping from 7 to 0 on entry to STOP.
REQ-021 byte_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-022 rst high at a clock edge SHALL force the state to IDLE, the timer, bit count and shift register to 0, byte_out to 8'h00, byte_valid, frame_err and busy to 0, and both synchronizer flops to 1.
REQ-023 rst asserted mid-frame SHALL discard the partial byte, and reception SHALL restart only on a new falling edge after rst deasserts.

Structure
REQ-024 Package uart_rx_pkg SHALL hold the state enumeration and a function computing DIV from CLK_HZ and BAUD.
REQ-025 The synchronizer SHALL be a separate sub-module, sync_2ff, with a reset value parameter.

Verification (CLK_HZ = 1_000_000, BAUD = 100_000, DIV = 10)
REQ-026 Frame 0xA5 -> byte_out = 8'hA5 with one byte_valid pulse about 2 + 95 cycles after the start edge, and frame_err = 0.
REQ-027 rxd low for 3 cycles then high -> FSM returns to IDLE, with no byte_valid, no frame_err and byte_out unchanged.
REQ-028 Frame 0x3C with a low stop bit held low for 40 cycles -> one frame_err pulse, byte_out stays 8'hA5, and the FSM stays in WAIT_HIGH until rxd rises.
REQ-029 Back-to-back frames 0x00 then 0xFF with no idle gap -> two byte_valid pulses, with byte_out = 8'h00 then 8'hFF.
REQ-030 rst pulsed during the 4th data bit -> byte_out = 8'h00 and busy = 0 next cycle, and the following frame 0x5A is received correctly.
